apb_regfile_slave: RTL
======================

Name: apb_regfile_slave

Overview:
Parametrised APB slave holding a bank of word-wide registers. It is the successor to the single-register slave and adds configurable data width, register count and wait states, PSTRB byte strobes, read-only register masking, and PSLVERR error responses. It sits behind the APB master on the peripheral bus and is intended as the generic control/status register block for new peripherals.

Parameters:
DATA_WIDTH, 32, bus and register width in bits; must be a multiple of 8.
ADDR_WIDTH, 32, PADDR width.
NUM_REGS, 16, number of registers; register i sits at byte address 4*i.
WAIT_STATES, 0, extra access-phase cycles before PREADY rises (0..15).
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only.

Ports:
PCLK  in  1  bus clock; all state changes on the rising edge.
PRESET  in  1  asynchronous, active-high reset.
PSEL  in  1  slave select.
PENABLE  in  1  access-phase indicator.
PWRITE  in  1  1=write, 0=read.
PADDR  in  ADDR_WIDTH  byte address.
PWDATA  in  DATA_WIDTH  write data.
PSTRB  in  DATA_WIDTH/8  write byte enables.
PRDATA  out  DATA_WIDTH  read data.
PREADY  out  1  transfer completes this cycle.
PSLVERR  out  1  error response; valid only when PREADY=1.

Behaviour:
- Reset (async, PRESET=1): FSM to IDLE, wait counter 0, all registers 0, PRDATA=0, PREADY=0, PSLVERR=0. Reset asserted mid-transfer aborts the transfer with no register update.
- FSM states and transitions:
  - IDLE -> ACCESS on an edge sampling PSEL=1, PENABLE=0 (setup phase). At that edge the slave captures the address decode and loads the counter with WAIT_STATES.
  - ACCESS holds while PSEL=1, PENABLE=1 and counter != 0. The counter decrements each edge.
  - ACCESS -> IDLE on the completing edge (PSEL & PENABLE & PREADY).
  - ACCESS -> IDLE if PSEL drops before completion. This is an abort: no write occurs.
  - A new setup phase may follow the completion cycle with no idle gap.
- PREADY is combinational: 1 when state=ACCESS, PSEL=1, PENABLE=1 and counter=0; otherwise 0. With WAIT_STATES=0 the access phase lasts exactly one cycle; with N it lasts N+1 cycles.
- Decode: index = PADDR >> 2. Error when PADDR[1:0] != 0 or index >= NUM_REGS.
- PSLVERR equals PREADY AND (decode error OR (PWRITE AND RO_MASK[index])). It is 0 whenever PREADY=0.
- Write: commits on the completing edge only, and only when PSLVERR=0. Byte k of the register is updated only if PSTRB[k]=1. PSTRB=0 is a legal write that changes nothing.
- Read: PRDATA = register[index] while PREADY=1 and there is no error; otherwise 0. PSTRB is ignored on reads. A read of an RO register is legal.
- PSEL & PENABLE sampled while in IDLE (missing setup phase): PREADY=1, PSLVERR=1 for that cycle, no state change, no write.
- Register contents are stable between transfers; aborted and errored transfers never modify state.

Test Plan:
1. Reset with defaults; write 0x00000309 to addr 0x0, 0x28122023 to 0x4, 0x416C656B to 0x8, 0x4C656500 to 0xC (PSTRB=0xF) -> each access phase is 1 cycle with PREADY=1, PSLVERR=0; read-back returns the same four values.
2. Byte strobes: reg 0x4 holds 0x28122023; write 0xAABBCCDD with PSTRB=0x5 -> reads 0x28BB20DD. Then write with PSTRB=0x0 -> value unchanged.
3. WAIT_STATES=3: write addr 0x8 -> PREADY low for 3 access cycles and high on the 4th; write lands only on that edge. A read shows the same timing, with PRDATA valid only while PREADY=1.
4. Errors with NUM_REGS=16: write 0xDEADBEEF to addr 0x40 -> PSLVERR=1 and no register changes. Read addr 0x6 -> PSLVERR=1, PRDATA=0. With RO_MASK=0x0002, write addr 0x4 -> PSLVERR=1 and old value kept; read addr 0x4 -> PSLVERR=0.
5. Abort/reset: WAIT_STATES=2, drop PSEL after 1 access cycle -> no write, FSM in IDLE. Pulse PRESET mid-access -> outputs 0 immediately and all registers read 0 afterwards.
6. Back-to-back transfers with no idle cycle (write 0x4 then read 0x4) -> both complete correctly. PENABLE=1 without a setup phase -> one-cycle PREADY=1, PSLVERR=1, no write.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave
//   Generic APB control/status register bank. Holds NUM_REGS registers of
//   DATA_WIDTH bits; register i lives at byte address 4*i. It supports
//   programmable wait states, byte strobes, per-register read-only masking
//   and PSLVERR for misaligned, out-of-range or read-only-write accesses.
//
// Ports
//   PCLK     in   bus clock, all state changes on the rising edge
//   PRESET   in   asynchronous active-high reset
//   PSEL     in   slave select
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address (ADDR_WIDTH)
//   PWDATA   in   write data (DATA_WIDTH)
//   PSTRB    in   write byte enables (DATA_WIDTH/8)
//   PRDATA   out  read data, non-zero only on a good completing read
//   PREADY   out  transfer completes this cycle (combinational)
//   PSLVERR  out  error response, only ever high together with PREADY
module apb_regfile_slave #(
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  ADDR_WIDTH  = 32,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  dec_err_q, dec_err_d;
    logic                  ro_q, ro_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  addr_err;
    logic                  ro_hit;
    logic                  setup;
    logic                  access_act;
    logic                  no_setup;
    logic                  complete;
    logic                  xfer_err;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_word;

    // Address decode of the live bus; only latched on the setup edge.
    always_comb begin
        word_idx = PADDR >> 2;
        addr_err = (PADDR[1:0] != 2'b00) || (word_idx >= ADDR_WIDTH'(NUM_REGS));
        ro_hit   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (word_idx == ADDR_WIDTH'(i)) begin
                ro_hit = RO_MASK[i];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    assign setup      = PSEL & ~PENABLE;
    assign access_act = (state_q == ST_ACCESS) & PSEL & PENABLE;
    // PENABLE seen without a preceding setup phase: answered with an
    // immediate one-cycle error and otherwise ignored.
    assign no_setup   = (state_q == ST_IDLE) & PSEL & PENABLE;
    assign complete   = access_act & (cnt_q == 4'd0);
    // PWRITE is stable for the whole transfer, so the read-only check can
    // combine the latched RO bit with the live direction.
    assign xfer_err   = dec_err_q | (PWRITE & ro_q);
    assign wr_en      = complete & PWRITE & ~xfer_err;

    // Outputs are forced low while reset is held, even if the bus is active.
    assign PREADY  = ~PRESET & (complete | no_setup);
    assign PSLVERR = ~PRESET & (no_setup | (complete & xfer_err));
    assign PRDATA  = (~PRESET & complete & ~xfer_err & ~PWRITE) ? rd_word : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        dec_err_d = dec_err_q;
        ro_d      = ro_q;
        if (setup) begin
            state_d   = ST_ACCESS;
            cnt_d     = 4'(WAIT_STATES);
            idx_d     = word_idx[IDX_W-1:0];
            dec_err_d = addr_err;
            ro_d      = ro_hit;
        end else if (state_q == ST_ACCESS) begin
            if (!PSEL || complete) begin
                // Completion, or PSEL dropped early (abort, nothing written).
                state_d = ST_IDLE;
            end else if (PENABLE) begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            dec_err_q <= 1'b0;
            ro_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            dec_err_q <= dec_err_d;
            ro_q      <= ro_d;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if ((idx_q == IDX_W'(i)) && PSTRB[k]) begin
                        regs_q[i][8*k +: 8] <= PWDATA[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule
